// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes nibble-wide READ/WRITE commands from the initiator and serves a byte array.
// Defining IDLI_SQI_MEM_MODE_EN adds an 8-bit mode register with WRMR (0x01) and RDMR (0x05) commands.
module idli_sqi_mem_m #(
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 65536,
    parameter int DUMMY_NIB = 2
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe,
    output logic       o_mem_busy
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int ADDR_NIB = ADDR_W / 4;
    localparam int CNT_W    = 8;

    localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(ADDR_NIB - 1);
    localparam logic [CNT_W-1:0]  DUMMY_LAST = CNT_W'(DUMMY_NIB - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK  = ADDR_W'(DEPTH - 1);

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
`ifdef IDLI_SQI_MEM_MODE_EN
    localparam logic [7:0] CMD_WRMR  = 8'h01;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
`endif

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RD_DATA,
        WR_DATA,
        ERR
`ifdef IDLI_SQI_MEM_MODE_EN
        ,
        WRMR,
        RDMR
`endif
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              sck_q;
    logic              rise;
    logic              fall;
    logic [CNT_W-1:0]  nib_cnt;
    logic              nib_lo;
    logic              is_read;
    logic [3:0]        cmd_hi;
    logic [3:0]        wr_hi;
    logic [7:0]        cmd;
    logic [7:0]        wr_byte;
    logic              wr_pend;
    logic [7:0]        rd_byte;
    logic              rd_start;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_shift;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        mem [DEPTH];
`ifdef IDLI_SQI_MEM_MODE_EN
    logic [7:0]        mode_reg;
`endif

    assign rise       = i_mem_sck & ~sck_q;
    assign fall       = ~i_mem_sck & sck_q;
    assign cmd        = {cmd_hi, i_mem_sio};
    assign addr_shift = (addr << 4) | ADDR_W'(i_mem_sio);
    assign addr_inc   = (addr + ADDR_W'(1)) & ADDR_MASK;
    assign o_mem_busy = (state != IDLE);

    // With no dummy phase the first byte is fetched from the address still being shifted in.
    assign rd_addr = (state == ADDR) ? addr_shift : addr;
    assign rd_byte = mem[rd_addr[IDX_W-1:0]];

    always_comb begin
        rd_start = 1'b0;
        if (!i_mem_cs && rise) begin
            if (state == ADDR && nib_cnt == ADDR_LAST && is_read && DUMMY_NIB == 0)
                rd_start = 1'b1;
            if (state == DUMMY && nib_cnt == DUMMY_LAST)
                rd_start = 1'b1;
        end
    end

    always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
        if (i_mem_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_mem_cs) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) state_nxt = CMD;
                CMD: begin
                    if (rise) begin
                        case (cmd)
                            CMD_READ, CMD_WRITE: state_nxt = ADDR;
`ifdef IDLI_SQI_MEM_MODE_EN
                            CMD_WRMR:            state_nxt = WRMR;
                            CMD_RDMR:            state_nxt = RDMR;
`endif
                            default:             state_nxt = ERR;
                        endcase
                    end
                end
                ADDR: begin
                    if (rise && nib_cnt == ADDR_LAST) begin
                        if (!is_read)
                            state_nxt = WR_DATA;
                        else if (DUMMY_NIB == 0)
                            state_nxt = RD_DATA;
                        else
                            state_nxt = DUMMY;
                    end
                end
                DUMMY: if (rise && nib_cnt == DUMMY_LAST) state_nxt = RD_DATA;
`ifdef IDLI_SQI_MEM_MODE_EN
                // Once the mode byte is complete, ERR serves as the ignore-until-deselect state.
                WRMR: if (rise && nib_lo) state_nxt = ERR;
`endif
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
        if (i_mem_rst) begin
            sck_q        <= 1'b0;
            o_mem_sio    <= 4'h0;
            o_mem_sio_oe <= 1'b0;
            addr         <= '0;
            nib_cnt      <= '0;
            nib_lo       <= 1'b0;
            is_read      <= 1'b0;
            cmd_hi       <= 4'h0;
            wr_hi        <= 4'h0;
            wr_byte      <= 8'h00;
            wr_pend      <= 1'b0;
`ifdef IDLI_SQI_MEM_MODE_EN
            mode_reg     <= 8'h40;
`endif
        end else begin
            sck_q   <= i_mem_sck;
            wr_pend <= 1'b0;
            if (wr_pend)
                addr <= addr_inc;
            if (i_mem_cs) begin
                o_mem_sio_oe <= 1'b0;
                nib_cnt      <= '0;
                nib_lo       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (rise) cmd_hi <= i_mem_sio;
                    CMD: begin
                        if (rise) begin
                            is_read <= (cmd == CMD_READ);
                            nib_cnt <= '0;
`ifdef IDLI_SQI_MEM_MODE_EN
                            if (cmd == CMD_RDMR) begin
                                o_mem_sio    <= mode_reg[7:4];
                                o_mem_sio_oe <= 1'b1;
                                nib_lo       <= 1'b1;
                            end
`endif
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            addr    <= addr_shift;
                            nib_cnt <= (nib_cnt == ADDR_LAST) ? '0 : nib_cnt + 1'b1;
                        end
                    end
                    DUMMY: if (rise) nib_cnt <= nib_cnt + 1'b1;
                    RD_DATA: begin
                        if (fall) begin
                            o_mem_sio <= nib_lo ? rd_byte[3:0] : rd_byte[7:4];
                            nib_lo    <= ~nib_lo;
                            if (nib_lo)
                                addr <= addr_inc;
                        end
                    end
                    WR_DATA: begin
                        if (rise) begin
                            if (nib_lo) begin
                                wr_byte <= {wr_hi, i_mem_sio};
                                wr_pend <= 1'b1;
                            end else begin
                                wr_hi <= i_mem_sio;
                            end
                            nib_lo <= ~nib_lo;
                        end
                    end
`ifdef IDLI_SQI_MEM_MODE_EN
                    WRMR: begin
                        if (rise) begin
                            if (nib_lo)
                                mode_reg <= {wr_hi, i_mem_sio};
                            else
                                wr_hi <= i_mem_sio;
                            nib_lo <= ~nib_lo;
                        end
                    end
                    RDMR: begin
                        if (fall) begin
                            o_mem_sio <= nib_lo ? mode_reg[3:0] : mode_reg[7:4];
                            nib_lo    <= ~nib_lo;
                        end
                    end
`endif
                    default: o_mem_sio_oe <= 1'b0;
                endcase
                if (rd_start) begin
                    o_mem_sio    <= rd_byte[7:4];
                    o_mem_sio_oe <= 1'b1;
                    nib_lo       <= 1'b1;
                end
            end
        end
    end

    // Array is deliberately left out of reset so contents survive a core reset.
    always_ff @(posedge i_mem_gck) begin
        if (wr_pend)
            mem[addr[IDX_W-1:0]] <= wr_byte;
    end

endmodule

// File: doc/idli_sqi_mem_m.md
Name: idli_sqi_mem_m

Overview:
- SQI serial-SRAM responder: the memory-side end of the core's SQI bus (o_top_sck/o_top_cs/o_top_sio).
- Decodes nibble-wide commands, addresses and data from the initiator, holds a byte-addressed array, and streams read data back on the shared SIO lines.
- Used as the synthesizable memory behind each SQI lane in FPGA builds and as the bench memory model for core-level tests.

Parameters:
- ADDR_W, 16, address width in bits; must be a multiple of 4; sent as ADDR_W/4 nibbles, MS nibble first.
- DEPTH, 65536, array size in bytes; power of 2, at most 2**ADDR_W; addresses are taken modulo DEPTH.
- DUMMY_NIB, 2, dummy nibbles between address and first read nibble.

Ports:
- i_mem_gck  in  1  clock; must run at least 2x the SCK rate.
- i_mem_rst  in  1  reset; asynchronous, active-high.
- i_mem_sck  in  1  serial clock from the initiator; sampled and edge-detected on i_mem_gck.
- i_mem_cs  in  1  chip select, active-low.
- i_mem_sio  in  sqi_data_t(4)  SIO lines driven by the initiator.
- o_mem_sio  out  sqi_data_t(4)  SIO lines driven by the responder.
- o_mem_sio_oe  out  1  high while the responder drives o_mem_sio.
- o_mem_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Edge detect:
  - sck_q is i_mem_sck registered; rise = sck & ~sck_q; fall = ~sck & sck_q.
  - Edges are acted on only while i_mem_cs = 0.
- Reset: state IDLE, sck_q 0, o_mem_sio 0, o_mem_sio_oe 0, o_mem_busy 0, address/nibble counters 0. The array is not reset.
- Chip select:
  - i_mem_cs = 1 at any clock forces state IDLE and oe 0 on the next cycle, including mid-command.
  - A partially received write byte is discarded.
- States:
  - IDLE: first rise with cs low captures the command high nibble -> CMD.
  - CMD: next rise captures the low nibble. 0x03 READ -> ADDR; 0x02 WRITE -> ADDR; any other code -> ERR.
  - ADDR: one nibble per rise, shifted in MS first. After ADDR_W/4 nibbles -> DUMMY for READ, WR_DATA for WRITE.
  - DUMMY: counts DUMMY_NIB rises, ignoring data, then -> RD_DATA.
  - RD_DATA:
    - On entry and on every fall, the next cycle drives o_mem_sio with the next nibble of mem[addr]: high nibble first, then low.
    - oe is 1 from the first driven nibble until cs goes high.
    - After the low nibble is driven, addr = (addr+1) mod DEPTH.
    - The stream runs indefinitely.
  - WR_DATA:
    - Rises alternate high then low nibble.
    - The cycle after the low nibble, mem[addr] is written and addr = (addr+1) mod DEPTH.
  - ERR: ignores all edges, oe 0, until cs goes high.
- A rise and a cs deassertion in the same cycle: cs wins; the nibble is ignored.
- o_mem_sio holds its last value when oe = 0. The value is don't-care for checking.

Optional Feature:
- Macro IDLI_SQI_MEM_MODE_EN.
- When defined:
  - Adds an 8-bit mode register, reset value 0x40.
  - Command 0x01 WRMR: the next two nibbles are written to the mode register; further nibbles are ignored until cs goes high.
  - Command 0x05 RDMR: no address or dummy phase. The mode register is streamed high then low nibble, repeating, with the same fall timing as RD_DATA.
  - The mode register value has no effect on array behaviour.
- When not defined: 0x01 and 0x05 decode as unknown and go to ERR.

Test Plan:
- WRITE 0x02, addr 0x0010, data 0xA5, 0x3C; then READ 0x03, addr 0x0010, 2 dummy -> 4 driven nibbles A,5,3,C; oe rises with the first nibble.
- WRITE at addr 0xFFFF (DEPTH=65536) of 0x11, 0x22 -> a READ from 0xFFFF returns 0x11 then 0x22, and mem[0x0000] = 0x22 (wrap).
- cs deasserted after 1 data nibble of a WRITE to addr 0x0040 -> mem[0x0040] unchanged; o_mem_busy low the next cycle.
- Command 0x7E followed by address and data edges -> oe stays 0, no array change, busy stays high until cs goes high; the next valid READ works.
- i_mem_rst pulsed mid-READ at addr 0x0100 -> next cycle oe 0, busy 0; the array keeps its prior contents on a subsequent READ.
- With IDLI_SQI_MEM_MODE_EN: RDMR after reset -> 4,0,4,0. WRMR 0x01 with 0x00, then RDMR -> 0,0. Without the macro: 0x05 -> oe stays 0.
